// File: rtl/cmd_rx_decoder.sv
// UART 8N1 receiver that decodes single-letter servo commands and issues them
// with a one-deep pending slot, a post-issue holdoff and a busy (moving) gate.
module cmd_rx_decoder #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned HOLDOFF      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       moving,
  output logic [2:0] state_desired,
  output logic       uart_command_valid,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       framing_err,
  output logic       unknown_cmd,
  output logic       cmd_dropped
);

  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned HoldW   = $clog2(HOLDOFF + 2);
  localparam int unsigned HalfBit = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} rx_state_e;

  rx_state_e        state_q;
  logic             rx_meta_q, rx_s_q;
  logic [CntW-1:0]  cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_byte_q;
  logic             rx_byte_valid_q, framing_err_q;

  logic [2:0]       state_desired_q, pend_q;
  logic             cmd_valid_q, pend_valid_q, unknown_q, drop_q;
  logic [HoldW-1:0] holdoff_q;

  logic [2:0]       dec_code;
  logic             is_term, new_cmd, can_issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver FSM; START waits half a bit so DATA/STOP sample mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      rx_byte_q       <= 8'h00;
      rx_byte_valid_q <= 1'b0;
      framing_err_q   <= 1'b0;
    end else begin
      rx_byte_valid_q <= 1'b0;
      framing_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q   <= StStart;
            cnt_q     <= '0;
            bit_idx_q <= '0;
          end
        end
        StStart: begin
          if (cnt_q == CntW'(HalfBit - 1)) begin
            cnt_q   <= '0;
            state_q <= rx_s_q ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= StStop;
            else bit_idx_q <= bit_idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              rx_byte_q       <= shift_q;
              rx_byte_valid_q <= 1'b1;
              state_q         <= StIdle;
            end else begin
              framing_err_q <= 1'b1;
              state_q       <= StWaitIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitIdle: begin
          if (rx_s_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    dec_code = 3'd0;
    is_term  = 1'b0;
    case (rx_byte_q)
      8'h69, 8'h49: dec_code = 3'd1;
      8'h70, 8'h50: dec_code = 3'd2;
      8'h6C, 8'h4C: dec_code = 3'd3;
      8'h65, 8'h45: dec_code = 3'd4;
      8'h74, 8'h54: dec_code = 3'd5;
      8'h75, 8'h55: dec_code = 3'd6;
      8'h64, 8'h44: dec_code = 3'd7;
      8'h0A, 8'h0D: is_term  = 1'b1;
      default: ;
    endcase
  end

  assign new_cmd   = rx_byte_valid_q && (dec_code != 3'd0);
  // The cmd_valid_q term keeps pulses apart even when HOLDOFF is zero.
  assign can_issue = !moving && (holdoff_q == '0) && !cmd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_desired_q <= 3'b001;
      cmd_valid_q     <= 1'b0;
      pend_q          <= 3'd0;
      pend_valid_q    <= 1'b0;
      unknown_q       <= 1'b0;
      drop_q          <= 1'b0;
      holdoff_q       <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      unknown_q   <= rx_byte_valid_q && (dec_code == 3'd0) && !is_term;
      if (holdoff_q != '0) holdoff_q <= holdoff_q - 1'b1;
      if (pend_valid_q && can_issue) begin
        state_desired_q <= pend_q;
        cmd_valid_q     <= 1'b1;
        holdoff_q       <= HoldW'(HOLDOFF);
        pend_valid_q    <= new_cmd;
        if (new_cmd) pend_q <= dec_code;
      end else if (new_cmd) begin
        if (can_issue) begin
          state_desired_q <= dec_code;
          cmd_valid_q     <= 1'b1;
          holdoff_q       <= HoldW'(HOLDOFF);
        end else begin
          drop_q       <= pend_valid_q;
          pend_q       <= dec_code;
          pend_valid_q <= 1'b1;
        end
      end
    end
  end

  assign state_desired      = state_desired_q;
  assign uart_command_valid = cmd_valid_q;
  assign rx_byte            = rx_byte_q;
  assign rx_byte_valid      = rx_byte_valid_q;
  assign framing_err        = framing_err_q;
  assign unknown_cmd        = unknown_q;
  assign cmd_dropped        = drop_q;

endmodule

// File: tb/tb_cmd_rx_decoder.sv
// Bench for cmd_rx_decoder: directed scenarios plus random byte streams checked
// against a transaction-level model of reception, decode and pending/drop rules.
module tb_cmd_rx_decoder;

  localparam int unsigned Cpb  = 16;
  localparam int unsigned Hold = 4;

  logic       clk = 1'b0;
  logic       rst_n, rx, moving;
  logic [2:0] state_desired;
  logic       uart_command_valid, rx_byte_valid, framing_err, unknown_cmd, cmd_dropped;
  logic [7:0] rx_byte;

  cmd_rx_decoder #(.CLKS_PER_BIT(Cpb), .HOLDOFF(Hold)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rx                 (rx),
    .moving             (moving),
    .state_desired      (state_desired),
    .uart_command_valid (uart_command_valid),
    .rx_byte            (rx_byte),
    .rx_byte_valid      (rx_byte_valid),
    .framing_err        (framing_err),
    .unknown_cmd        (unknown_cmd),
    .cmd_dropped        (cmd_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {logic [2:0] code; bit direct;} exp_cmd_t;

  int unsigned n_cmp = 0, n_err = 0;
  logic [7:0]  exp_bytes[$];
  exp_cmd_t    exp_cmds[$];
  int unsigned exp_unknown = 0, exp_framing = 0, exp_drops = 0;
  int unsigned obs_unknown = 0, obs_framing = 0, obs_drops = 0;
  logic [2:0]  pend_code = 3'd0;
  bit          pend_v = 1'b0;
  logic        rxv_prev = 1'b0, cv_prev = 1'b0;
  logic [7:0]  mon_byte;
  exp_cmd_t    mon_cmd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Command code = 1 + position of the lower-cased letter in "ipletud".
  function automatic logic [2:0] model_decode(input logic [7:0] b);
    string       letters = "ipletud";
    logic  [7:0] lc;
    lc = (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
    for (int i = 0; i < 7; i++) if (letters[i] == lc) return 3'(i + 1);
    return 3'd0;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit bad_stop);
    logic [2:0] c;
    exp_cmd_t   e;
    if (bad_stop) begin
      exp_framing++;
      return;
    end
    exp_bytes.push_back(b);
    c = model_decode(b);
    if (c != 3'd0) begin
      if (moving) begin
        if (pend_v) exp_drops++;
        pend_code = c;
        pend_v    = 1'b1;
      end else begin
        e.code = c; e.direct = 1'b1;
        exp_cmds.push_back(e);
      end
    end else if (b != 8'h0A && b != 8'h0D) begin
      exp_unknown++;
    end
  endtask

  task automatic set_moving(input logic v);
    exp_cmd_t e;
    @(negedge clk);
    if (!v && moving && pend_v) begin
      e.code = pend_code; e.direct = 1'b0;
      exp_cmds.push_back(e);
      pend_v = 1'b0;
    end
    moving = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    model_byte(b, bad_stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx = !bad_stop;
    repeat (Cpb) @(negedge clk);
    rx = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
  endtask

  task automatic check_counts();
    check("unknown_cnt", obs_unknown, exp_unknown);
    check("framing_cnt", obs_framing, exp_framing);
    check("drop_cnt", obs_drops, exp_drops);
    check("cmds_left", exp_cmds.size(), 0);
    check("bytes_left", exp_bytes.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_state", state_desired, 3'b001);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_pulses", {uart_command_valid, rx_byte_valid, framing_err, unknown_cmd,
                         cmd_dropped}, 5'b0);
  endtask

  always @(negedge clk) begin
    if (rx_byte_valid) begin
      if (exp_bytes.size() == 0) check("rxv_spurious", 1, 0);
      else begin
        mon_byte = exp_bytes.pop_front();
        check("rx_byte", rx_byte, mon_byte);
      end
    end
    if (uart_command_valid) begin
      check("cmd_b2b", cv_prev, 0);
      if (exp_cmds.size() == 0) check("cmd_spurious", 1, 0);
      else begin
        mon_cmd = exp_cmds.pop_front();
        check("state_desired", state_desired, mon_cmd.code);
        if (mon_cmd.direct) check("issue_lat", rxv_prev, 1);
      end
    end
    if (unknown_cmd) obs_unknown++;
    if (framing_err) obs_framing++;
    if (cmd_dropped) obs_drops++;
    rxv_prev <= rx_byte_valid;
    cv_prev  <= uart_command_valid;
  end

  initial begin
    #(600_000);
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    string       letters = "ipletud";
    logic  [7:0] b;
    int unsigned r;
    rst_n = 1'b0; rx = 1'b1; moving = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_byte(8'h74, 1'b0);
    check("t_state", state_desired, 3'b101);
    check_counts();

    set_moving(1'b1);
    send_byte(8'h70, 1'b0);
    send_byte(8'h45, 1'b0);
    check("pend_drop", obs_drops, 1);
    set_moving(1'b0);
    check("e_state", state_desired, 3'b100);
    check_counts();

    send_byte(8'h74, 1'b1);
    send_byte(8'h69, 1'b0);
    check("i_state", state_desired, 3'b001);
    check_counts();

    send_byte(8'h78, 1'b0);
    send_byte(8'h0D, 1'b0);
    check_counts();

    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
    check_counts();
    send_byte(8'h6C, 1'b0);
    check("l_state", state_desired, 3'b011);

    // Abandon 'u' partway through its data bits.
    b = 8'h75;
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx = b[3];
    repeat (Cpb / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h64, 1'b0);
    check("d_state", state_desired, 3'b111);
    check_counts();

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) set_moving(!moving);
      r = $urandom_range(0, 99);
      if (r < 55) begin
        b = letters[$urandom_range(0, 6)];
        if ($urandom_range(0, 1) == 1) b = b - 8'h20;
      end else if (r < 70) begin
        b = ($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0D;
      end else begin
        b = 8'($urandom_range(0, 255));
      end
      send_byte(b, $urandom_range(0, 9) == 0);
    end
    set_moving(1'b0);
    repeat (50) @(negedge clk);
    check_counts();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_rx_decoder.md
CMD_RX_DECODER -- requirements
Module: cmd_rx_decoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234, clocks per UART bit (27 MHz / 115200).
REQ-002 SHALL have parameter HOLDOFF, default 4, minimum number of clocks after an issued command before the next one may issue.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx  input  1  UART serial line, 8N1, LSB first, idle high, asynchronous to clk.
REQ-006 SHALL have port moving  input  1  high while the downstream servo stage is executing a movement.
REQ-007 SHALL have port state_desired  output  3  command code of the last issued command.
REQ-008 SHALL have port uart_command_valid  output  1  one-clock pulse that issues state_desired.
REQ-009 SHALL have port rx_byte  output  8  last correctly framed received byte.
REQ-010 SHALL have port rx_byte_valid  output  1  one-clock pulse when rx_byte updates.
REQ-011 SHALL have port framing_err  output  1  one-clock pulse when a stop bit samples low.
REQ-012 SHALL have port unknown_cmd  output  1  one-clock pulse when a framed byte is not a command or terminator.
REQ-013 SHALL have port cmd_dropped  output  1  one-clock pulse when a pending command is overwritten.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all receiver decisions use the synchronized value rx_s.
REQ-015 SHALL implement receiver FSM with states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-016 In IDLE, rx_s==0 SHALL move the FSM to START and clear the bit counter.
REQ-017 In START, after CLKS_PER_BIT/2 clocks, rx_s==0 SHALL move the FSM to DATA; rx_s==1 SHALL return it to IDLE (glitch) with no output.
REQ-018 In DATA, the receiver SHALL sample rx_s every CLKS_PER_BIT clocks into bits 0..7 (LSB first), then go to STOP.
REQ-019 In STOP, after CLKS_PER_BIT clocks, rx_s==1 SHALL load rx_byte, pulse rx_byte_valid, and go to IDLE.
REQ-020 In STOP, rx_s==0 SHALL pulse framing_err, discard the byte, and go to WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL stay until rx_s==1, then go to IDLE.
REQ-022 Decode SHALL occur in the cycle rx_byte_valid is high, case-insensitive: i->001, p->010, l->011, e->100, t->101, u->110, d->111.
REQ-023 Bytes 0x0A and 0x0D SHALL be ignored silently; any other byte SHALL pulse unknown_cmd one cycle after rx_byte_valid.
REQ-024 A decoded command SHALL issue when moving==0, no command is pending, and the holdoff counter is zero.
REQ-025 Issue SHALL update state_desired and pulse uart_command_valid for exactly one clock, one cycle after rx_byte_valid, and SHALL load the holdoff counter with HOLDOFF.
REQ-026 A decoded command that cannot issue SHALL be stored in a one-deep pending register.
REQ-027 If the pending register is already full, the new command SHALL overwrite it and pulse cmd_dropped.
REQ-028 A pending command SHALL issue on the first cycle with moving==0 and holdoff zero, and the pending register SHALL then clear.
REQ-029 If a pending issue and a new decode occur in the same cycle, the pending command SHALL issue and the new one SHALL become pending.
REQ-030 uart_command_valid SHALL never be high in two consecutive cycles.
REQ-031 The holdoff counter SHALL decrement to zero and saturate there.

Reset
REQ-032 rst_n low SHALL immediately force: FSM=IDLE, synchronizer flops=1, state_desired=3'b001, rx_byte=8'h00, all pulse outputs=0, pending cleared, holdoff=0.
REQ-033 Reset mid-frame SHALL abandon the frame; after release, reception SHALL restart on the next start bit.

Verification (CLKS_PER_BIT=16)
REQ-034 Send 't' (0x74) with moving=0 -> rx_byte=0x74, then state_desired=101 with a single uart_command_valid pulse one cycle after rx_byte_valid.
REQ-035 Hold moving=1 and send 'p' then 'E' -> cmd_dropped pulses once; on moving falling, state_desired=100 with one pulse only.
REQ-036 Send 0x74 with the stop bit low -> framing_err pulses, no rx_byte_valid, no uart_command_valid; then rx high and send 'i' -> state_desired=001 issued.
REQ-037 Send 'x', then 0x0D -> unknown_cmd pulses once (for 'x' only) and no command is issued.
REQ-038 Apply a 4-clock low glitch on rx -> no outputs pulse and the FSM returns to IDLE.
REQ-039 Assert rst_n low during DATA of 'u' -> outputs reach their reset values immediately; the next 'd' issues state_desired=111.
